// File: rtl/du_pkg.sv
// -----------------------------------------------------------------------------
// du_pkg -- shared definitions for the GELU divider unit (DU).
//
// Holds the default operand/mantissa/fraction widths, the exponent-width helper
// and the stage payload structs for the default configuration. Blocks that
// allow width overrides build their own payload types of the same shape.
// -----------------------------------------------------------------------------
package du_pkg;

    localparam int DU_W    = 32;  // operand width, shared with the LOD
    localparam int DU_MW   = 16;  // normalized mantissa width
    localparam int DU_FRAC = 16;  // fraction bits of the fixed-point operand

    // Exponent width: enough for lod_pos - FRAC (+1 for a rounding carry), signed.
    function automatic int du_ew(input int w);
        return $clog2(w) + 2;
    endfunction

    localparam int DU_EW = du_ew(DU_W);

    // S1 payload: left-justified operand, unbiased exponent, zero flag.
    typedef struct packed {
        logic [DU_W-1:0]         sh;
        logic signed [DU_EW-1:0] e;
        logic                    z;
    } norm_s1_t;

    // S2 payload: what the normalizer presents downstream.
    typedef struct packed {
        logic [DU_MW-1:0]        mant;
        logic signed [DU_EW-1:0] exp;
        logic                    zero;
    } norm_out_t;

endpackage

// File: rtl/lod_norm_round.sv
// -----------------------------------------------------------------------------
// lod_norm_round -- combinational mantissa extraction and rounding between the
// two normalizer pipeline stages.
//
// Build option: define LOD_NORM_ROUND_EN for round-to-nearest-even with carry
// renormalization; leave it undefined to truncate (no carry path is built).
//
// Ports:
//   sh    in  W   left-justified operand (leading one at bit W-1 unless zero)
//   e     in  EW  signed exponent of sh
//   z     in  1   operand was zero
//   mant  out MW  normalized mantissa (0 when z)
//   exp   out EW  signed exponent (0 when z)
//   zero  out 1   copy of z
// -----------------------------------------------------------------------------
module lod_norm_round
    import du_pkg::*;
#(
    parameter  int W  = DU_W,
    parameter  int MW = DU_MW,
    localparam int EW = du_ew(W)
) (
    input  logic [W-1:0]         sh,
    input  logic signed [EW-1:0] e,
    input  logic                 z,
    output logic [MW-1:0]        mant,
    output logic signed [EW-1:0] exp,
    output logic                 zero
);

    logic [MW-1:0]        m;
    logic [MW-1:0]        mant_r;
    logic signed [EW-1:0] exp_r;

    assign m = sh[W-1 -: MW];

`ifdef LOD_NORM_ROUND_EN
    logic        g;
    logic        s;
    logic        inc;
    logic [MW:0] sum;

    assign g = sh[W-MW-1];
    assign s = |sh[W-MW-2:0];

    always_comb begin
        // Nearest-even: round up above half, or at exactly half when m is odd.
        inc = g && (s || m[0]);
        sum = {1'b0, m} + {{MW{1'b0}}, inc};
        if (sum[MW]) begin
            // m was all ones: the result is exactly 2.0, renormalize to 1.0 * 2^(e+1).
            mant_r = {1'b1, {(MW-1){1'b0}}};
            exp_r  = e + EW'(1);
        end else begin
            mant_r = sum[MW-1:0];
            exp_r  = e;
        end
    end
`else
    // Truncation discards everything below the mantissa.
    logic unused_lsbs;
    assign unused_lsbs = ^sh[W-MW-1:0];

    assign mant_r = m;
    assign exp_r  = e;
`endif

    // A zero operand overrides whatever the shifter produced.
    assign mant = z ? '0 : mant_r;
    assign exp  = z ? '0 : exp_r;
    assign zero = z;

endmodule

// File: rtl/lod_norm.sv
// -----------------------------------------------------------------------------
// lod_norm -- normalizer stage of the GELU divider unit.
//
// Takes the leading-one position from the LOD with the aligned operand and
// produces a left-justified mantissa plus signed exponent such that
//   value = mant_out / 2^(MW-1) * 2^exp_out.
// Two-stage elastic pipeline, valid/ready on both sides, 1 result/cycle.
//
// Build option: LOD_NORM_ROUND_EN selects round-to-nearest-even in
// lod_norm_round; undefined truncates.
//
// Ports:
//   clk        in  1          rising-edge clock
//   rst        in  1          asynchronous active-high reset
//   valid_in   in  1          upstream beat valid
//   ready_out  out 1          block can accept a beat (combinational from ready_in)
//   data_in    in  W          operand, Q(W-FRAC).FRAC, aligned with LOD outputs
//   lod_pos    in  $clog2(W)  leading-one position (trusted, not cross-checked)
//   found      in  1          operand non-zero
//   valid_out  out 1          result valid
//   ready_in   in  1          downstream accepts the result
//   mant_out   out MW         normalized mantissa, MSB set unless zero
//   exp_out    out EW         signed exponent
//   zero_out   out 1          operand was zero
// -----------------------------------------------------------------------------
module lod_norm
    import du_pkg::*;
#(
    parameter  int W    = DU_W,
    parameter  int MW   = DU_MW,
    parameter  int FRAC = DU_FRAC,
    localparam int EW   = du_ew(W),
    localparam int LW   = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [W-1:0]         data_in,
    input  logic [LW-1:0]        lod_pos,
    input  logic                 found,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [MW-1:0]        mant_out,
    output logic signed [EW-1:0] exp_out,
    output logic                 zero_out
);

    typedef struct packed {
        logic [W-1:0]         sh;
        logic signed [EW-1:0] e;
        logic                 z;
    } s1_t;

    typedef struct packed {
        logic [MW-1:0]        mant;
        logic signed [EW-1:0] exp;
        logic                 zero;
    } s2_t;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic                 s2_ready;
    logic                 s1_adv;
    logic                 accept;
    logic [LW-1:0]        shamt;
    logic [MW-1:0]        rnd_mant;
    logic signed [EW-1:0] rnd_exp;
    logic                 rnd_zero;

    // Distance that brings the leading one up to bit W-1.
    assign shamt = LW'(W-1) - lod_pos;

    lod_norm_round #(
        .W  (W),
        .MW (MW)
    ) u_round (
        .sh   (s1_q.sh),
        .e    (s1_q.e),
        .z    (s1_q.z),
        .mant (rnd_mant),
        .exp  (rnd_exp),
        .zero (rnd_zero)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        // S2 can take new content when empty or when its result leaves this cycle.
        s2_ready  = !s2_valid_q || ready_in;
        s1_adv    = s1_valid_q && s2_ready;
        ready_out = !s1_valid_q || s2_ready;
        accept    = valid_in && ready_out;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.sh    = data_in << shamt;
            s1_d.e     = $signed(EW'(lod_pos)) - $signed(EW'(FRAC));
            s1_d.z     = !found;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.mant = rnd_mant;
                s2_d.exp  = rnd_exp;
                s2_d.zero = rnd_zero;
            end
        end
    end

    // NOTE: data registers are reset too, so mant/exp/zero read 0 while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign valid_out = s2_valid_q;
    assign mant_out  = s2_q.mant;
    assign exp_out   = s2_q.exp;
    assign zero_out  = s2_q.zero;

endmodule

// File: tb/tb_lod_norm.sv
// -----------------------------------------------------------------------------
// tb_lod_norm -- directed self-checking bench for lod_norm (W=32, MW=16, FRAC=16).
// Expected values are hand-computed; those that differ with LOD_NORM_ROUND_EN
// are selected by the same macro.
// -----------------------------------------------------------------------------
module tb_lod_norm;
    import du_pkg::*;

    localparam int W    = 32;
    localparam int MW   = 16;
    localparam int FRAC = 16;
    localparam int EW   = du_ew(W);

`ifdef LOD_NORM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [W-1:0]  data_in = '0;
    logic [4:0]    lod_pos = '0;
    logic          found = 1'b0;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic          zero_out;

    int n_cmp = 0;
    int n_bad = 0;

    lod_norm #(
        .W    (W),
        .MW   (MW),
        .FRAC (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .lod_pos   (lod_pos),
        .found     (found),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .zero_out  (zero_out)
    );

    always #5 clk = ~clk;

    // Backpressure beats and their expected results.
    logic [31:0]   bp_d [4] = '{32'h0001_8000, 32'h8000_8000, 32'h8001_8000, 32'h0000_0001};
    logic [4:0]    bp_p [4] = '{5'd16, 5'd31, 5'd31, 5'd0};
    logic [MW-1:0] bp_m [4] = '{16'hC000, 16'h8000, (RND ? 16'h8002 : 16'h8001), 16'h8000};
    logic [EW-1:0] bp_e [4] = '{7'h00, 7'h0F, 7'h0F, 7'h70};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] p, input logic f);
        valid_in = 1'b1;
        data_in  = d;
        lod_pos  = p;
        found    = f;
    endtask

    // One beat through an idle pipe with ready_in high; checks 2-cycle latency.
    task automatic single(input string tag, input logic [31:0] d, input logic [4:0] p,
                          input logic f, input logic [MW-1:0] em, input logic [EW-1:0] ee,
                          input logic ez);
        ready_in = 1'b1;
        drive(d, p, f);
        #1;
        check({tag, "/ready_out"}, ready_out, 1);
        step();
        valid_in = 1'b0;
        check({tag, "/early_valid"}, valid_out, 0);
        step();
        check({tag, "/valid"}, valid_out, 1);
        check({tag, "/mant"}, mant_out, em);
        check({tag, "/exp"}, exp_out, ee);
        check({tag, "/zero"}, zero_out, ez);
        step();
    endtask

    initial begin
        int  sent;
        int  got;
        bit  fire;

        // Reset values while rst is held.
        #2;
        check("rst/valid_out", valid_out, 0);
        check("rst/mant", mant_out, 0);
        check("rst/exp", exp_out, 0);
        check("rst/zero", zero_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst/ready_out", ready_out, 1);

        // Basic directed vectors.
        single("basic_1p5", 32'h0001_8000, 5'd16, 1'b1, 16'hC000, 7'd0, 1'b0);
        single("all_ones", 32'hFFFF_8000, 5'd31, 1'b1,
               RND ? 16'h8000 : 16'hFFFF, RND ? 7'd16 : 7'd15, 1'b0);
        single("tie_even", 32'h8000_8000, 5'd31, 1'b1, 16'h8000, 7'd15, 1'b0);
        single("tie_odd", 32'h8001_8000, 5'd31, 1'b1,
               RND ? 16'h8002 : 16'h8001, 7'd15, 1'b0);
        single("sticky", 32'h1234_C001, 5'd31, 1'b1,
               RND ? 16'h1235 : 16'h1234, 7'd15, 1'b0);
        single("min_exp", 32'h0000_0001, 5'd0, 1'b1, 16'h8000, 7'h70, 1'b0);
        single("zero", 32'hDEAD_BEEF, 5'd5, 1'b0, 16'h0000, 7'd0, 1'b1);

        // Backpressure: four back-to-back beats, ready_in low for the first 5 cycles.
        ready_in = 1'b0;
        sent = 0;
        got  = 0;
        drive(bp_d[0], bp_p[0], 1'b1);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            ready_in = (cyc >= 5);
            #1;
            if (cyc == 1) check("bp/ready_one_held", ready_out, 1);
            if (cyc >= 2 && cyc < 5) check("bp/ready_full", ready_out, 0);
            if (valid_out && !ready_in) begin
                check("bp/stall_mant", mant_out, bp_m[got]);
                check("bp/stall_exp", exp_out, bp_e[got]);
            end
            if (valid_out && ready_in) begin
                check("bp/mant", mant_out, bp_m[got]);
                check("bp/exp", exp_out, bp_e[got]);
                got++;
            end
            fire = valid_in && ready_out;
            step();
            if (fire) begin
                sent++;
                if (sent < 4) drive(bp_d[sent], bp_p[sent], 1'b1);
                else valid_in = 1'b0;
            end
        end
        check("bp/received", got, 4);
        check("bp/sent", sent, 4);
        #1;
        check("bp/no_dup", valid_out, 0);

        // Asynchronous reset with both stages full.
        ready_in = 1'b0;
        drive(32'h0001_8000, 5'd16, 1'b1);
        step();
        drive(32'h8000_8000, 5'd31, 1'b1);
        step();
        valid_in = 1'b0;
        #1;
        check("arst/pre_valid", valid_out, 1);
        check("arst/pre_ready", ready_out, 0);
        #2 rst = 1'b1;
        #1;
        check("arst/valid_out", valid_out, 0);
        check("arst/mant", mant_out, 0);
        check("arst/exp", exp_out, 0);
        check("arst/zero", zero_out, 0);
        step();
        rst = 1'b0;
        #1;
        check("arst/ready_out", ready_out, 1);
        single("post_rst", 32'h0001_8000, 5'd16, 1'b1, 16'hC000, 7'd0, 1'b0);
        check("post_rst/drained", valid_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
